// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: converter state encoding, display sizes and 7-segment patterns.
package bcd_display_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
   localparam int NUM_DIGITS = 3;
   localparam int BIN_W = 8;
   localparam int BCD_W = 12;
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_OFF = 7'h00;
   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      case (d)
         4'd0: return SEG_0;
         4'd1: return SEG_1;
         4'd2: return SEG_2;
         4'd3: return SEG_3;
         4'd4: return SEG_4;
         4'd5: return SEG_5;
         4'd6: return SEG_6;
         4'd7: return SEG_7;
         4'd8: return SEG_8;
         4'd9: return SEG_9;
         default: return SEG_OFF;
      endcase
   endfunction
endpackage

// File: rtl/bcd_display_if.sv
// bcd_display_if: value input plus segment/anode/busy outputs of the display block.
interface bcd_display_if;
   import bcd_display_pkg::*;
   logic [BIN_W-1:0] value;
   logic [6:0] seg;
   logic [NUM_DIGITS-1:0] an;
   logic busy;
   modport master (output value, input seg, an, busy);
   modport slave (input value, output seg, an, busy);
endinterface

// File: rtl/bcd_display_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, converts value_q whenever it differs from the last converted value.
module bin2bcd_seq
   import bcd_display_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BIN_W-1:0] value_q,
   output logic [BCD_W-1:0] disp,
   output logic             busy
);
   state_t state_q;
   logic [BIN_W-1:0] last_q;
   logic [BCD_W+BIN_W-1:0] sr_q, sr_adj;
   logic [2:0] cnt_q;
   logic [BCD_W-1:0] disp_q;
   always_comb begin
      sr_adj = sr_q;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (sr_q[BIN_W+4*i +: 4] >= 4'd5) sr_adj[BIN_W+4*i +: 4] = sr_q[BIN_W+4*i +: 4] + 4'd3;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= '0;
         sr_q    <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (value_q != last_q) begin
               sr_q    <= {{BCD_W{1'b0}}, value_q};
               last_q  <= value_q;
               cnt_q   <= '0;
               state_q <= SHIFT;
            end
            SHIFT: begin
               sr_q  <= {sr_adj[BCD_W+BIN_W-2:0], 1'b0};
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_q <= COMMIT;
            end
            COMMIT: begin
               disp_q  <= sr_q[BCD_W+BIN_W-1 -: BCD_W];
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign disp = disp_q;
   assign busy = state_q != IDLE;
endmodule

// File: rtl/bcd_display.sv
// bcd_display: 3-digit multiplexed 7-segment decimal display of an 8-bit value.
// Define BCD_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_display
   import bcd_display_pkg::*;
#(
   parameter int SCAN_BITS      = 16,
   parameter bit SEG_ACTIVE_LOW = 1,
   parameter bit AN_ACTIVE_LOW  = 1
)(
   input logic           clk,
   input logic           rst_n,
   bcd_display_if.slave  bus
);
   localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_INV = AN_ACTIVE_LOW ? '1 : '0;
   logic [BIN_W-1:0] value_q;
   logic [BCD_W-1:0] disp;
   logic busy;
   logic [SCAN_BITS-1:0] scan_q, scan_d;
   logic [1:0] idx_q, idx_d;
   logic [6:0] seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [3:0] digit;
   logic blank;
   bin2bcd_seq u_conv (.clk(clk), .rst_n(rst_n), .value_q(value_q), .disp(disp), .busy(busy));
   always_comb begin
      scan_d = scan_q + SCAN_BITS'(1);
      idx_d  = (&scan_q) ? (idx_q >= 2'd2 ? 2'd0 : idx_q + 2'd1) : (idx_q == 2'd3 ? 2'd0 : idx_q);
      digit  = idx_q == 2'd0 ? disp[3:0] : idx_q == 2'd1 ? disp[7:4] : disp[11:8];
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
      blank  = (idx_q == 2'd2 && disp[11:8] == 4'd0) || (idx_q == 2'd1 && disp[11:4] == 8'd0);
`else
      blank  = 1'b0;
`endif
      an_d   = (blank ? '0 : NUM_DIGITS'(1) << idx_q) ^ AN_INV;
      seg_d  = (blank ? SEG_OFF : seg_encode(digit)) ^ SEG_INV;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
         scan_q  <= '0;
         idx_q   <= '0;
         seg_q   <= SEG_INV;
         an_q    <= AN_INV;
      end else begin
         value_q <= bus.value;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end
   assign bus.seg  = seg_q;
   assign bus.an   = an_q;
   assign bus.busy = busy;
endmodule

// File: tb/tb_bcd_display.sv
// tb_bcd_display: random and directed conversions checked against a decimal/scan-slot reference model.
module tb_bcd_display;
   logic clk = 0;
   logic rst_n = 0;
   int n_chk = 0;
   int n_err = 0;
   int ec = 0;
   int cur = 0;
   logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   bcd_display_if bif ();
   bcd_display #(.SCAN_BITS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
   always #5 clk = ~clk;
   // edges since reset release; the scan slot shown after edge e is ((e-1)/16)%3
   always @(posedge clk or negedge rst_n) ec <= !rst_n ? 0 : ec + 1;
   function automatic logic [9:0] exp_out(int v, int e);
      int slot, d;
      logic blank;
      logic [2:0] a;
      logic [6:0] s;
      slot = ((e - 1) / 16) % 3;
      d = slot == 0 ? v % 10 : slot == 1 ? (v / 10) % 10 : v / 100;
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
      blank = (slot == 2 && v < 100) || (slot == 1 && v < 10);
`else
      blank = 1'b0;
`endif
      a = blank ? 3'b000 : 3'(1 << slot);
      s = blank ? 7'h00 : pat[d];
      return {~a, ~s};
   endfunction
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic sample_out(int v);
      logic [9:0] x;
      x = exp_out(v, ec);
      check("an", bif.an, x[9:7]);
      check("seg", bif.seg, x[6:0]);
   endtask
   task automatic check_display(int v, int n);
      for (int i = 0; i < n; i++) begin
         sample_out(v);
         check("busy_idle", bif.busy, 0);
         tick();
      end
   endtask
   task automatic conv_wait(int v);
      for (int k = 1; k <= 11; k++) begin
         tick();
         check("busy", bif.busy, k >= 2 && k <= 10);
      end
      tick();
      check_display(v, 50);
      cur = v;
   endtask
   task automatic conv(int v);
      bif.value = 8'(v);
      conv_wait(v);
   endtask
   initial begin
      int v;
      bif.value = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_an", bif.an, 3'b111);
      check("rst_seg", bif.seg, 7'h7F);
      check("rst_busy", bif.busy, 0);
      rst_n = 1;
      tick();
      check_display(0, 60);
      conv(255);
      bif.value = 8'd100;
      repeat (5) tick();
      #2;
      rst_n = 0;
      #1;
      check("mid_rst_an", bif.an, 3'b111);
      check("mid_rst_seg", bif.seg, 7'h7F);
      check("mid_rst_busy", bif.busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      conv_wait(100);
      bif.value = 8'd8;
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k == 3) bif.value = 8'd9;
         check("b2b_busy", bif.busy, (k >= 2 && k <= 10) || (k >= 12 && k <= 20));
         if (k >= 12) sample_out(8);
      end
      tick();
      check_display(9, 50);
      cur = 9;
      conv(5);
      conv(105);
      conv(10);
      conv(0);
      repeat (20) begin
         do v = int'($urandom_range(0, 255)); while (v == cur);
         conv(v);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
